// File: rtl/uart_tx_queue.sv
// Byte FIFO plus send sequencer in front of a UART transmitter: pops one byte,
// strobes tx_send for one cycle, then holds tx_byte until the transmitter's done pulse.
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            tx_byte,
    output logic                  tx_send,
    input  logic                  tx_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(32'd1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    state_t                state_q, state_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_send_q, tx_send_d;

    logic full_s, empty_s, wr_accept_s, pop_s;

    // Occupancy flags and the two per-edge FIFO events; full is judged before any pop.
    always_comb begin
        full_s      = (count_q == CNT_FULL);
        empty_s     = (count_q == CNT_ZERO);
        wr_accept_s = wr_en && !full_s;
        pop_s       = (state_q == ST_IDLE) && !empty_s;
    end

    // Storage, pointers, occupancy counter and sticky overflow.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_accept_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Send sequencer: tx_done only matters while waiting on an in-flight frame.
    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d   = ST_SEND;
                    tx_byte_d = mem_q[rd_ptr_q];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tx_send_d = (state_d == ST_SEND);
    end

    // State register; reset drops any queued bytes and silences the transmitter side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '{default: 8'h00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_byte_q  <= 8'h00;
            tx_send_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            tx_send_q  <= tx_send_d;
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = !empty_s || (state_q != ST_IDLE);
    assign tx_byte  = tx_byte_q;
    assign tx_send  = tx_send_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized and directed bench for uart_tx_queue against a queue-based reference model.
module tb_uart_tx_queue;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   wr_data;
    logic         wr_en;
    logic         full, empty, overflow, busy, tx_send;
    logic [DL2:0] count;
    logic [7:0]   tx_byte;
    logic         tx_done;
    logic         auto_done_s = 1'b0;
    logic         man_done_s = 1'b0;

    assign tx_done = auto_done_s | man_done_s;

    int checks = 0;
    int errors = 0;

    // reference model: bytes queued, byte owned by the transmitter, pulse this cycle
    logic [7:0] mq[$];
    logic [7:0] m_byte = 8'h00;
    bit         m_out = 1'b0;
    bit         m_sent = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_size_old;
    bit         m_pop, m_ack;

    logic [7:0] sent[$];
    int         sent_cnt[$];

    bit auto_en = 1'b0;
    int done_min = 1;
    int done_max = 4;
    int done_cnt = -1;

    always #5 clk = ~clk;

    uart_tx_queue #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .tx_byte(tx_byte), .tx_send(tx_send), .tx_done(tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_byte = 8'h00; m_out = 1'b0; m_sent = 1'b0; m_ovf = 1'b0;
        end else begin
            m_size_old = mq.size();
            m_pop  = !m_out && (m_size_old > 0);
            m_ack  = m_out && !m_sent && (tx_done === 1'b1);
            m_sent = 1'b0;
            if (m_ack) m_out = 1'b0;
            if (m_pop) begin
                m_byte = mq.pop_front();
                m_out  = 1'b1;
                m_sent = 1'b1;
            end
            if (wr_en === 1'b1) begin
                if (m_size_old == DEPTH) m_ovf = 1'b1;
                else mq.push_back(wr_data);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("busy", 32'(busy), 32'((mq.size() > 0) || m_out));
        chk("tx_send", 32'(tx_send), 32'(m_sent));
        chk("tx_byte", 32'(tx_byte), 32'(m_byte));
        if (tx_send === 1'b1) begin
            sent.push_back(tx_byte);
            sent_cnt.push_back(int'(count));
        end
    end

    // transmitter stand-in: answers each tx_send with tx_done after a chosen delay
    initial forever begin
        @(posedge clk);
        #1;
        auto_done_s = 1'b0;
        if (rst) done_cnt = -1;
        else if (tx_send && auto_en) done_cnt = int'($urandom_range(done_max, done_min));
        else if (done_cnt > 0) done_cnt--;
        if (done_cnt == 0) begin
            auto_done_s = 1'b1;
            done_cnt = -1;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        man_done_s = 1'b1;
        cyc(1);
        man_done_s = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget, input string name);
        int k = 0;
        while (sent.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(sent.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            cyc(1);
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] exp_q[$];
        int exp_cnt[5];
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        cyc(2);
        rst = 1'b0;
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_tx_byte", 32'(tx_byte), 32'h00);

        // single byte
        write_byte(8'hA5);
        chk("e0_count", 32'(count), 32'd1);
        chk("e0_busy", 32'(busy), 32'd1);
        chk("e0_send", 32'(tx_send), 32'd0);
        cyc(1);
        chk("e1_send", 32'(tx_send), 32'd1);
        chk("e1_byte", 32'(tx_byte), 32'hA5);
        chk("e1_count", 32'(count), 32'd0);
        cyc(1);
        chk("e2_send", 32'(tx_send), 32'd0);
        cyc(5);
        chk("hold_byte", 32'(tx_byte), 32'hA5);
        pulse_done();
        chk("single_busy", 32'(busy), 32'd0);
        cyc(3);

        // burst order with a 20-cycle transmitter
        sent.delete(); sent_cnt.delete();
        done_min = 20; done_max = 20; auto_en = 1'b1;
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        wait_sent(5, 400, "burst_sent");
        wait_idle(100, "burst_idle");
        exp_cnt = '{1, 3, 2, 1, 0};
        for (int i = 0; i < 5 && i < sent.size(); i++) begin
            chk("burst_byte", 32'(sent[i]), 32'(i + 1));
            chk("burst_count", 32'(sent_cnt[i]), 32'(exp_cnt[i]));
        end

        // wrap-around
        done_min = 1; done_max = 5;
        for (int r = 0; r < 3; r++) begin
            sent.delete(); exp_q.delete();
            for (int i = 0; i < 12; i++) begin
                e = 8'($urandom);
                exp_q.push_back(e);
                write_byte(e);
            end
            wait_sent(12, 400, "wrap_sent");
            wait_idle(100, "wrap_idle");
            for (int i = 0; i < 12 && i < sent.size(); i++) chk("wrap_byte", 32'(sent[i]), 32'(exp_q[i]));
            chk("wrap_count", 32'(count), 32'd0);
            chk("wrap_empty", 32'(empty), 32'd1);
        end

        // simultaneous write and pop with one byte queued
        auto_en = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        cyc(1);
        chk("sim_pre_count", 32'(count), 32'd1);
        man_done_s = 1'b1;
        cyc(1);
        man_done_s = 1'b0;
        write_byte(8'h3C);
        chk("sim_count", 32'(count), 32'd1);
        chk("sim_send1", 32'(tx_byte), 32'h22);
        cyc(1);
        pulse_done();
        cyc(1);
        chk("sim_send2", 32'(tx_send), 32'd1);
        chk("sim_byte2", 32'(tx_byte), 32'h3C);
        cyc(1);
        pulse_done();
        wait_idle(20, "sim_idle");

        // full / overflow with the sequencer parked in WAIT
        write_byte(8'h80);
        cyc(2);
        for (int i = 0; i < 17; i++) begin
            write_byte(8'h40 + 8'(i));
            if (i == 14) chk("not_full_15", 32'(full), 32'd0);
            if (i == 15) chk("full_16", 32'(full), 32'd1);
        end
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("full_count", 32'(count), 32'd16);
        sent.delete();
        done_min = 1; done_max = 4; auto_en = 1'b1;
        pulse_done();
        wait_sent(16, 600, "drain_sent");
        cyc(40);
        chk("drain_total", 32'(sent.size()), 32'd16);
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            e = 8'h40 + 8'(i);
            chk("drain_byte", 32'(sent[i]), 32'(e));
        end
        chk("drain_busy", 32'(busy), 32'd0);

        // asynchronous reset while waiting with three bytes queued
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'h91 + 8'(i));
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_send", 32'(tx_send), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'h00);
        #1 rst = 1'b0;
        cyc(5);
        pulse_done();
        for (int i = 0; i < 5; i++) begin
            chk("stray_done_send", 32'(tx_send), 32'd0);
            cyc(1);
        end
        chk("stray_done_busy", 32'(busy), 32'd0);

        // randomized traffic
        auto_en = 1'b1; done_min = 1; done_max = 8;
        for (int i = 0; i < 600; i++) begin
            wr_en = ($urandom_range(99, 0) < 60) ? 1'b1 : 1'b0;
            wr_data = 8'($urandom);
            cyc(1);
        end
        wr_en = 1'b0;
        wait_idle(2000, "rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
